operand_sel_pipe: RTL and testbench

Parametrised N-way operand select stage with a registered, flow-controlled output, used in the pipelined RISC-V datapath wherever forwarded operands (register file, EX/MEM, MEM/WB, immediate, …) are chosen and handed to the next stage. It generalises the fixed 3:1 32-bit forwarding select to any width and input count. It adds a valid/ready handshake, a 2-entry skid buffer so back-pressure never drops data, and a pipeline flush.

---
 rtl/operand_sel_pipe.sv | 85 ++++++++
 tb/tb_operand_sel_pipe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/operand_sel_pipe.sv
// rtl/operand_sel_pipe.sv - N-way operand select with registered valid/ready output and 2-entry skid buffer
// Optional out-of-range select counter enabled by OPSEL_ERR_CNT_EN.
module operand_sel_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             err_cnt
);

    logic [WIDTH-1:0] mux_val;
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             accept;

    // Unmatched select values fall through to the constant-zero default.
    always_comb begin
        mux_val = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                mux_val = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // A held skid beat is older than anything arriving, so it drains first.
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_data  <= mux_val;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= mux_val;
            skid_valid <= 1'b1;
        end
    end

`ifdef OPSEL_ERR_CNT_EN
    logic sel_oor;
    logic [15:0] err_q;

    assign sel_oor = int'(sel) >= NUM_IN;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 16'h0;
        end else if (accept && sel_oor && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'h1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_operand_sel_pipe.sv
// tb/tb_operand_sel_pipe.sv - directed self-checking bench for operand_sel_pipe (4-input and 3-input instances)
module tb_operand_sel_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;

    logic [127:0] in_bus;
    logic [1:0]   sel;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  err_cnt;

    logic [95:0]  in3_bus;
    logic [1:0]   sel3;
    logic         in3_valid;
    logic         in3_ready;
    logic [31:0]  out3_data;
    logic         out3_valid;
    logic         out3_ready;
    logic [15:0]  err3_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_seq [4];

    always #5 clk = ~clk;

    operand_sel_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut (
        .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .err_cnt(err_cnt)
    );

    operand_sel_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_bus(in3_bus), .sel(sel3), .in_valid(in3_valid),
        .in_ready(in3_ready), .flush(flush), .out_data(out3_data), .out_valid(out3_valid),
        .out_ready(out3_ready), .err_cnt(err3_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic put(input logic [31:0] v);
        in_bus = {4{v}};
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        in_bus = '0; sel = 2'd0; in_valid = 1'b0; out_ready = 1'b0;
        in3_bus = '0; sel3 = 2'd0; in3_valid = 1'b0; out3_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_err_cnt", err_cnt, 0);

        // Back-to-back select of all four lanes
        exp_seq = '{32'h11, 32'h22, 32'h33, 32'h44};
        in_bus = {32'h44, 32'h33, 32'h22, 32'h11};
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            step();
            check($sformatf("b2b_data_%0d", i), out_data, exp_seq[i]);
            check($sformatf("b2b_valid_%0d", i), out_valid, 1);
        end
        in_valid = 1'b0;
        step();
        check("b2b_idle_valid", out_valid, 0);

        // Three-input instance: in-range and out-of-range selects
        in3_bus = {32'd3, 32'd2, 32'd1};
        out3_ready = 1'b1;
        in3_valid = 1'b1;
        sel3 = 2'd2;
        step();
        check("sel3_in_range", out3_data, 3);
        sel3 = 2'd3;
        step();
        in3_valid = 1'b0;
        check("sel3_oor_data", out3_data, 0);
        check("sel3_oor_valid", out3_valid, 1);
`ifdef OPSEL_ERR_CNT_EN
        check("sel3_err_cnt", err3_cnt, 1);
`else
        check("sel3_err_cnt", err3_cnt, 0);
`endif

        // Stall with skid fill, then drain in order
        sel = 2'd0;
        put(32'hA0); in_valid = 1'b1; out_ready = 1'b1;
        step();
        check("stall_main_a0", out_data, 32'hA0);
        out_ready = 1'b0;
        put(32'hA1);
        step();
        check("stall_hold_a0", out_data, 32'hA0);
        check("stall_in_ready", in_ready, 0);
        put(32'hA2);
        step();
        step();
        check("stall_hold_a0_3", out_data, 32'hA0);
        check("stall_in_ready_3", in_ready, 0);
        out_ready = 1'b1;
        step();
        check("drain_a1", out_data, 32'hA1);
        check("drain_in_ready", in_ready, 1);
        step();
        check("drain_a2", out_data, 32'hA2);
        put(32'hA3);
        step();
        check("drain_a3", out_data, 32'hA3);
        in_valid = 1'b0;
        step();
        check("drain_idle", out_valid, 0);

        // Flush with main and skid full plus an incoming beat
        out_ready = 1'b0; in_valid = 1'b1;
        put(32'hC1);
        step();
        put(32'hC2);
        step();
        check("flush_pre_in_ready", in_ready, 0);
        flush = 1'b1; put(32'hBB);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        check("flush_no_bb", out_valid, 0);

        // Reset mid-stream with skid full
        out_ready = 1'b0; in_valid = 1'b1;
        put(32'hD1);
        step();
        put(32'hD2);
        step();
        check("rst_pre_in_ready", in_ready, 0);
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_err3_cnt", err3_cnt, 0);
        in_valid = 1'b1; out_ready = 1'b1; put(32'hE5);
        step();
        in_valid = 1'b0;
        check("rst_next_data", out_data, 32'hE5);
        check("rst_next_valid", out_valid, 1);

`ifdef OPSEL_ERR_CNT_EN
        // Counter saturation after 65537 out-of-range accepts
        sel3 = 2'd3; in3_valid = 1'b1; out3_ready = 1'b1;
        repeat (65535) step();
        check("sat_65535", err3_cnt, 16'hFFFF);
        repeat (2) step();
        in3_valid = 1'b0;
        check("sat_65537", err3_cnt, 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
